branch_predictor: RTL

- Fetch-stage branch predictor for the pipelined core: a direct-mapped branch target buffer with 2-bit saturating counters.
- IF looks it up combinationally with the fetch PC. EX trains it with the branch-unit outcome (taken flag and resolved target).
- It also produces a registered mispredict/redirect pulse that the hazard unit uses to flush IF/ID and ID/EX.
- It is the consumer of the branch-resolution result, and it drives the speculative side of fetch.

---
 rtl/branch_predictor_if.sv | 35 +++
 rtl/branch_predictor.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/branch_predictor_if.sv
// Bundles the fetch-lookup, EX-update and redirect/statistics signals of the
// branch predictor.
//   master : core side (drives fetch PC and branch resolution, consumes
//            prediction, redirect and perf counters)
//   slave  : predictor side
interface branch_predictor_if;
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
               perf_branches, perf_mispredicts
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        output pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
               perf_branches, perf_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating
// counters, combinational lookup, one-cycle-latency training from EX and a
// registered mispredict/redirect pulse for the hazard unit.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bp    : branch_predictor_if.slave (lookup, update, redirect, perf)
// Optional feature: define BP_STATS_EN to instantiate the saturating
// branch / mispredict counters; otherwise the perf outputs are tied to 0.
module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bp
);
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDX;

    logic            valid_q  [ENTRIES];
    logic [TAGW-1:0] tag_q    [ENTRIES];
    logic [31:0]     target_q [ENTRIES];
    logic [1:0]      ctr_q    [ENTRIES];

    logic [IDX-1:0]  lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic [IDX-1:0]  up_idx;
    logic [TAGW-1:0] up_tag;
    logic            up_hit;

    logic            ent_we;
    logic [1:0]      ent_ctr_d;
    logic [31:0]     ent_tgt_d;

    logic            mis_cond;
    logic            mispredict_q;
    logic [31:0]     redirect_q, redirect_d;

    // Fetch PCs are word aligned; the low bits carry no information.
    logic            unused_pc_bits;
    assign unused_pc_bits = ^bp.if_pc[1:0];

    // Lookup reads only registered state, so a same-cycle update is not seen.
    assign lk_idx = bp.if_pc[IDX+1:2];
    assign lk_tag = bp.if_pc[31:IDX+2];

    assign bp.pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign bp.pred_taken  = bp.pred_hit && ctr_q[lk_idx][1];
    assign bp.pred_target = bp.pred_hit ? target_q[lk_idx] : bp.if_pc + 32'd4;

    assign up_idx = bp.upd_pc[IDX+1:2];
    assign up_tag = bp.upd_pc[31:IDX+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        ent_we    = 1'b0;
        ent_ctr_d = ctr_q[up_idx];
        ent_tgt_d = target_q[up_idx];
        if (bp.upd_valid) begin
            if (up_hit) begin
                ent_we = 1'b1;
                if (bp.upd_taken) begin
                    ent_ctr_d = (ctr_q[up_idx] == 2'd3) ? 2'd3 : ctr_q[up_idx] + 2'd1;
                    ent_tgt_d = bp.upd_target;
                end else begin
                    ent_ctr_d = (ctr_q[up_idx] == 2'd0) ? 2'd0 : ctr_q[up_idx] - 2'd1;
                end
            end else if (bp.upd_taken) begin
                // Allocation evicts whatever alias lives at this index.
                ent_we    = 1'b1;
                ent_ctr_d = 2'b10;
                ent_tgt_d = bp.upd_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (ent_we) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= ent_tgt_d;
            ctr_q[up_idx]    <= ent_ctr_d;
        end
    end

    // A correct "taken" direction still mispredicts if the target was wrong.
    assign mis_cond = bp.upd_valid &&
                      ((bp.upd_taken != bp.upd_pred_taken) ||
                       (bp.upd_taken && bp.upd_pred_taken &&
                        (bp.upd_target != bp.upd_pred_target)));

    assign redirect_d = !bp.upd_valid ? redirect_q :
                        bp.upd_taken  ? bp.upd_target : bp.upd_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
        end else begin
            mispredict_q <= mis_cond;
            redirect_q   <= redirect_d;
        end
    end

    assign bp.mispredict  = mispredict_q;
    assign bp.redirect_pc = redirect_q;

`ifdef BP_STATS_EN
    logic [31:0] perf_br_q, perf_br_d;
    logic [31:0] perf_mis_q, perf_mis_d;

    assign perf_br_d  = (bp.upd_valid && perf_br_q != 32'hFFFF_FFFF)
                        ? perf_br_q + 32'd1 : perf_br_q;
    assign perf_mis_d = (mis_cond && perf_mis_q != 32'hFFFF_FFFF)
                        ? perf_mis_q + 32'd1 : perf_mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else begin
            perf_br_q  <= perf_br_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    assign bp.perf_branches    = perf_br_q;
    assign bp.perf_mispredicts = perf_mis_q;
`else
    assign bp.perf_branches    = 32'd0;
    assign bp.perf_mispredicts = 32'd0;
`endif
endmodule
